fork_join_ctrl: RTL and testbench
=================================

// Module: fork_join_ctrl
// PURPOSE
//  Hardware sequencer for parallel jobs, same scheme as fork/join_any test flows.
//  On go: pulses start to N_JOBS parallel workers, then waits per join mode: all, any or none.
//  Then launches one follow-on (post) job and reports completion.
//  Sits between a test/command sequencer and a bank of independent worker engines.
// PARAMETERS
//  N_JOBS     3   number of parallel worker jobs (2..16)
//  TMO_W      16  width of watchdog counter (used only with FJ_TIMEOUT_EN)
// PORTS
//  clk         in   1          rising-edge clock
//  rst_n       in   1          async active-low reset
//  go          in   1          start request; sampled only in IDLE
//  mode        in   2          join mode, latched with go: 0=JOIN_ALL 1=JOIN_ANY 2=JOIN_NONE 3=rsvd (treated as JOIN_ALL)
//  job_start   out  N_JOBS     one-cycle start pulse per worker
//  job_done    in   N_JOBS     one-cycle done pulse per worker
//  post_start  out  1          one-cycle start pulse to follow-on job
//  post_done   in   1          one-cycle done pulse from follow-on job
//  busy        out  1          high in every state except IDLE
//  done        out  1          one-cycle pulse at sequence end
//  first_id    out  clog2(N)   index of first worker to finish (valid at done)
//  pending     out  N_JOBS     workers started but not yet done
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; pending=0; first_id=0. Async assert, sync deassert in system.
//  States: IDLE -> FORK -> WAIT -> POST -> PWAIT -> FIN -> IDLE.
//  IDLE: go=1 latches mode; next FORK. go in any other state is ignored.
//  FORK: job_start = all ones for exactly 1 cycle; pending <= all ones.
//    JOIN_NONE -> POST; otherwise -> WAIT.
//  WAIT: each job_done[i] with pending[i]=1 clears pending[i].
//    job_done[i] with pending[i]=0 is ignored (no error, no state change).
//    The first cycle with any valid done captures first_id = lowest set index (simultaneous dones: lowest wins).
//    first_id is captured once per sequence.
//    JOIN_ANY: -> POST on the cycle after the first valid done.
//    JOIN_ALL: -> POST on the cycle after pending reaches 0.
//  POST: post_start=1 for 1 cycle; -> PWAIT.
//  PWAIT: post_done -> FIN. Workers still pending keep being tracked (dones clear pending bits).
//  FIN: done=1 for 1 cycle; -> IDLE. pending is NOT cleared; stragglers may still clear bits in IDLE.
//    The next FORK overwrites pending.
//  A post_done before PWAIT is ignored.
//  Latency (JOIN_NONE, post_done same cycle as post_start seen): go@T -> job_start@T+1 -> post_start@T+2 -> done@T+4 minimum.
//  Reset mid-sequence: immediate return to IDLE, all outputs 0; any in-flight jobs are forgotten.
// CONFIGURATION
//  FJ_TIMEOUT_EN defined:
//    TMO_W-bit counter runs in WAIT and PWAIT and clears on state entry.
//    On reaching all-ones: -> FIN, done pulses, and extra output timeout (1 bit) = 1 for that cycle.
//    timeout resets to 0.
//  FJ_TIMEOUT_EN undefined: no counter and no timeout port; WAIT/PWAIT may wait indefinitely.
// STRUCTURE
//  Package fork_join_pkg: state enum (IDLE, FORK, WAIT, POST, PWAIT, FIN),
//    mode constants (JOIN_ALL=2'd0, JOIN_ANY=2'd1, JOIN_NONE=2'd2).
//  Sub-module fj_job_tracker: pending-mask register and lowest-index priority encoder.
//    Ports: clk, rst_n, set_all, done_in, pending, any_valid, first_idx.
//  The top contains the FSM, mode latch and optional watchdog.
// TESTING
//  JOIN_ANY, done[0]@+5, [1]@+10, [2]@+15, post_done 5 cycles after post_start
//    -> post_start the cycle after done[0]; first_id=0; done pulses; pending ends 0.
//  JOIN_ALL, dones at +15, +5, +10 -> post_start one cycle after done of job 0 (last, +15); first_id=1.
//  JOIN_NONE -> post_start 1 cycle after job_start; pending=3'b111 at post_start.
//  JOIN_ANY with job_done=3'b110 in the same cycle -> first_id=1; pending=3'b001.
//  Spurious job_done[1] in IDLE, go held high during WAIT, rst_n low in PWAIT
//    -> all ignored; then immediate IDLE with outputs 0.
//  FJ_TIMEOUT_EN, TMO_W=4, no job_done in JOIN_ALL -> timeout and done pulse after 15 WAIT cycles; no post_start.

Source files
------------

// File: rtl/fork_join_pkg.sv
// Shared FSM state codes and join-mode encodings for the fork/join sequencer.
package fork_join_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned MODE_W  = 2;

  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] FORK  = 3'd1;
  localparam logic [STATE_W-1:0] WAIT  = 3'd2;
  localparam logic [STATE_W-1:0] POST  = 3'd3;
  localparam logic [STATE_W-1:0] PWAIT = 3'd4;
  localparam logic [STATE_W-1:0] FIN   = 3'd5;

  localparam logic [MODE_W-1:0] JOIN_ALL  = 2'd0;
  localparam logic [MODE_W-1:0] JOIN_ANY  = 2'd1;
  localparam logic [MODE_W-1:0] JOIN_NONE = 2'd2;

  // The reserved encoding behaves as JOIN_ALL.
  function automatic logic [MODE_W-1:0] norm_mode(input logic [MODE_W-1:0] m);
    return (m == JOIN_ANY || m == JOIN_NONE) ? m : JOIN_ALL;
  endfunction

endpackage

// File: rtl/fj_job_tracker.sv
// Pending-mask register for the worker bank plus a lowest-index encoder over
// the done pulses that hit a still-pending worker.
module fj_job_tracker
  import fork_join_pkg::*;
#(
  parameter int unsigned N_JOBS = 3,
  parameter int unsigned ID_W   = $clog2(N_JOBS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_all,
  input  logic [N_JOBS-1:0] done_in,
  output logic [N_JOBS-1:0] pending,
  output logic              any_valid,
  output logic [ID_W-1:0]   first_idx
);

  logic [N_JOBS-1:0] pending_q;
  logic [N_JOBS-1:0] pending_d;
  logic [N_JOBS-1:0] valid;

  // Dones for workers that are not pending fall out of the AND and are ignored.
  always_comb begin
    valid     = done_in & pending_q;
    pending_d = set_all ? {N_JOBS{1'b1}} : (pending_q & ~done_in);
    first_idx = '0;
    for (int i = int'(N_JOBS) - 1; i >= 0; i--) begin
      if (valid[i]) first_idx = ID_W'(i);
    end
  end

  assign any_valid = |valid;
  assign pending   = pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join sequencer: starts N_JOBS workers, joins per mode, runs a post job.
// Optional watchdog on WAIT/PWAIT is enabled by defining FJ_TIMEOUT_EN.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int unsigned N_JOBS = 3
`ifdef FJ_TIMEOUT_EN
  , parameter int unsigned TMO_W = 16
`endif
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       go,
  input  logic [1:0]                 mode,
  output logic [N_JOBS-1:0]          job_start,
  input  logic [N_JOBS-1:0]          job_done,
  output logic                       post_start,
  input  logic                       post_done,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(N_JOBS)-1:0]  first_id,
  output logic [N_JOBS-1:0]          pending
`ifdef FJ_TIMEOUT_EN
  , output logic                     timeout
`endif
);

  localparam int unsigned ID_W = $clog2(N_JOBS);

  logic [STATE_W-1:0] state_q, state_d;
  logic [MODE_W-1:0]  mode_q, mode_d;
  logic [ID_W-1:0]    first_id_q, first_id_d;
  logic               fid_seen_q, fid_seen_d;
  logic [N_JOBS-1:0]  job_start_q, job_start_d;
  logic               post_start_q, post_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               set_all;
  logic               any_valid;
  logic [ID_W-1:0]    first_idx;
  logic               all_clear;

`ifdef FJ_TIMEOUT_EN
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               timeout_q, timeout_d;
  logic               tmo_hit;

  assign tmo_hit = &tmo_q;
`endif

  fj_job_tracker #(
    .N_JOBS (N_JOBS),
    .ID_W   (ID_W)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_all   (set_all),
    .done_in   (job_done),
    .pending   (pending),
    .any_valid (any_valid),
    .first_idx (first_idx)
  );

  // JOIN_ALL completes on the cycle whose dones clear the last pending bit.
  assign all_clear = ~|(pending & ~job_done);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    first_id_d = first_id_q;
    fid_seen_d = fid_seen_q;
    set_all    = 1'b0;
`ifdef FJ_TIMEOUT_EN
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (go) begin
          mode_d  = norm_mode(mode);
          state_d = FORK;
        end
      end
      FORK: begin
        set_all    = 1'b1;
        first_id_d = '0;
        fid_seen_d = 1'b0;
        state_d    = (mode_q == JOIN_NONE) ? POST : WAIT;
      end
      WAIT: begin
        if (any_valid && !fid_seen_q) begin
          first_id_d = first_idx;
          fid_seen_d = 1'b1;
        end
        if ((mode_q == JOIN_ANY) ? any_valid : all_clear) begin
          state_d = POST;
        end
`ifdef FJ_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d   = FIN;
          timeout_d = 1'b1;
        end
`endif
      end
      POST: state_d = PWAIT;
      PWAIT: begin
        if (post_done) begin
          state_d = FIN;
        end
`ifdef FJ_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d   = FIN;
          timeout_d = 1'b1;
        end
`endif
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs decode the next state so they are flopped in step with state_q.
    job_start_d  = {N_JOBS{(state_d == FORK)}};
    post_start_d = (state_d == POST);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
  end

`ifdef FJ_TIMEOUT_EN
  // Watchdog restarts from zero on every state entry.
  always_comb begin
    tmo_d = '0;
    if ((state_q == WAIT || state_q == PWAIT) && state_d == state_q) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= JOIN_ALL;
      first_id_q   <= '0;
      fid_seen_q   <= 1'b0;
      job_start_q  <= '0;
      post_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      first_id_q   <= first_id_d;
      fid_seen_q   <= fid_seen_d;
      job_start_q  <= job_start_d;
      post_start_q <= post_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign job_start  = job_start_q;
  assign post_start = post_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign first_id   = first_id_q;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Self-checking bench for fork_join_ctrl: directed join scenarios plus random
// sequences checked cycle by cycle against an event-time reference model.
module tb_fork_join_ctrl;
  import fork_join_pkg::*;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         go;
  logic [1:0]   mode;
  logic [N-1:0] job_start;
  logic [N-1:0] job_done;
  logic         post_start;
  logic         post_done;
  logic         busy;
  logic         done;
  logic [1:0]   first_id;
  logic [N-1:0] pending;
`ifdef FJ_TIMEOUT_EN
  logic         timeout;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  int dly   [N];
  int extra [N];
  logic [N-1:0] model_pend = '0;

  int           obs_post_cyc;
  int           obs_done_cyc;
  logic [1:0]   obs_fid;
  logic [N-1:0] obs_pend_post;
  logic [N-1:0] obs_pend_end;

  always #5 clk = ~clk;

  fork_join_ctrl #(.N_JOBS(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .go         (go),
    .mode       (mode),
    .job_start  (job_start),
    .job_done   (job_done),
    .post_start (post_start),
    .post_done  (post_done),
    .busy       (busy),
    .done       (done),
    .first_id   (first_id),
    .pending    (pending)
`ifdef FJ_TIMEOUT_EN
    , .timeout  (timeout)
`endif
  );

  // Cycle 0 drives go; worker i pulses done in cycle 1+dly[i] (plus an optional
  // repeat extra[i] cycles later); post_done arrives pd cycles after post_start.
  task automatic run_seq(input logic [1:0] m, input int pd, input bit early_pd, input bit hold_go);
    logic [1:0]   em;
    logic [N-1:0] e_pend;
    int tfirst, tlast, fid, p_cyc, f_cyc, k_end, c;
    em = (m == 2'd3) ? JOIN_ALL : m;
    tfirst = 1 << 30;
    tlast  = 0;
    fid    = 0;
    k_end  = 0;
    e_pend = model_pend;
    for (int i = 0; i < N; i++) begin
      c = 1 + dly[i];
      if (c < tfirst) begin tfirst = c; fid = i; end
      if (c > tlast) tlast = c;
      if (c + extra[i] > k_end) k_end = c + extra[i];
    end
    if (em == JOIN_NONE)     p_cyc = 2;
    else if (em == JOIN_ANY) p_cyc = tfirst + 1;
    else                     p_cyc = tlast + 1;
    f_cyc = p_cyc + pd + 1;
    if (f_cyc > k_end) k_end = f_cyc;
    k_end += 2;
    obs_post_cyc  = -1;
    obs_done_cyc  = -1;
    obs_fid       = 2'b11;
    obs_pend_post = 'x;
    for (int k = 0; k <= k_end; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) e_pend[i] = (k <= 1) ? model_pend[i] : (k <= 1 + dly[i]);
      n_tests += 5;
      if (job_start !== ((k == 1) ? 3'b111 : 3'b000)) begin
        n_fail++; $display("FAIL job_start k=%0d: got %b expected %b", k, job_start, (k == 1) ? 3'b111 : 3'b000);
      end
      if (post_start !== (k == p_cyc)) begin
        n_fail++; $display("FAIL post_start k=%0d: got %b expected %b", k, post_start, k == p_cyc);
      end
      if (done !== (k == f_cyc)) begin
        n_fail++; $display("FAIL done k=%0d: got %b expected %b", k, done, k == f_cyc);
      end
      if (busy !== (k >= 1 && k <= f_cyc)) begin
        n_fail++; $display("FAIL busy k=%0d: got %b expected %b", k, busy, k >= 1 && k <= f_cyc);
      end
      if (pending !== e_pend) begin
        n_fail++; $display("FAIL pending k=%0d: got %b expected %b", k, pending, e_pend);
      end
      if (k == f_cyc && em != JOIN_NONE) begin
        n_tests++;
        if (first_id !== 2'(fid)) begin
          n_fail++; $display("FAIL first_id k=%0d: got %0d expected %0d", k, first_id, fid);
        end
      end
      if (post_start === 1'b1) begin obs_post_cyc = k; obs_pend_post = pending; end
      if (done === 1'b1) begin obs_done_cyc = k; obs_fid = first_id; end
      go   = (k == 0) || (hold_go && k >= 1 && k <= f_cyc);
      mode = (k == 0) ? m : 2'($urandom_range(0, 3));
      for (int i = 0; i < N; i++)
        job_done[i] = (k == 1 + dly[i]) || (extra[i] > 0 && k == 1 + dly[i] + extra[i]);
      post_done = (k == p_cyc + pd) || (early_pd && k == p_cyc);
    end
    obs_pend_end = pending;
    model_pend   = e_pend;
    go        = 1'b0;
    job_done  = '0;
    post_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; go = 1'b0; mode = 2'd0; job_done = '0; post_done = 1'b0;
    repeat (2) @(negedge clk);
    n_tests += 7;
    if (job_start !== 3'b000) begin n_fail++; $display("FAIL rst_job_start: got %b expected 000", job_start); end
    if (post_start !== 1'b0)  begin n_fail++; $display("FAIL rst_post_start: got %b expected 0", post_start); end
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (done !== 1'b0)        begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
    if (first_id !== 2'd0)    begin n_fail++; $display("FAIL rst_first_id: got %0d expected 0", first_id); end
    if (pending !== 3'b000)   begin n_fail++; $display("FAIL rst_pending: got %b expected 000", pending); end
    rst_n = 1'b1;
    @(negedge clk);
    if (busy !== 1'b0)        begin n_fail++; $display("FAIL rst_idle_busy: got %b expected 0", busy); end
    model_pend = '0;
  endtask

  task automatic test_join_any();
    dly = '{5, 10, 15}; extra = '{0, 0, 0};
    run_seq(JOIN_ANY, 5, 1'b0, 1'b0);
    n_tests += 4;
    if (obs_post_cyc !== 7)   begin n_fail++; $display("FAIL any_post_cyc: got %0d expected 7", obs_post_cyc); end
    if (obs_done_cyc !== 13)  begin n_fail++; $display("FAIL any_done_cyc: got %0d expected 13", obs_done_cyc); end
    if (obs_fid !== 2'd0)     begin n_fail++; $display("FAIL any_first_id: got %0d expected 0", obs_fid); end
    if (obs_pend_end !== '0)  begin n_fail++; $display("FAIL any_pend_end: got %b expected 000", obs_pend_end); end
  endtask

  task automatic test_join_all();
    dly = '{15, 5, 10}; extra = '{0, 2, 0};
    run_seq(JOIN_ALL, 3, 1'b1, 1'b0);
    n_tests += 3;
    if (obs_post_cyc !== 17)  begin n_fail++; $display("FAIL all_post_cyc: got %0d expected 17", obs_post_cyc); end
    if (obs_done_cyc !== 21)  begin n_fail++; $display("FAIL all_done_cyc: got %0d expected 21", obs_done_cyc); end
    if (obs_fid !== 2'd1)     begin n_fail++; $display("FAIL all_first_id: got %0d expected 1", obs_fid); end
  endtask

  task automatic test_join_none();
    dly = '{4, 6, 8}; extra = '{0, 0, 0};
    run_seq(JOIN_NONE, 1, 1'b0, 1'b0);
    n_tests += 3;
    if (obs_post_cyc !== 2)        begin n_fail++; $display("FAIL none_post_cyc: got %0d expected 2", obs_post_cyc); end
    if (obs_pend_post !== 3'b111)  begin n_fail++; $display("FAIL none_pend_post: got %b expected 111", obs_pend_post); end
    if (obs_done_cyc !== 4)        begin n_fail++; $display("FAIL none_done_cyc: got %0d expected 4", obs_done_cyc); end
  endtask

  task automatic test_simultaneous();
    dly = '{6, 3, 3}; extra = '{0, 0, 0};
    run_seq(JOIN_ANY, 2, 1'b0, 1'b1);
    n_tests += 3;
    if (obs_post_cyc !== 5)        begin n_fail++; $display("FAIL sim_post_cyc: got %0d expected 5", obs_post_cyc); end
    if (obs_fid !== 2'd1)          begin n_fail++; $display("FAIL sim_first_id: got %0d expected 1", obs_fid); end
    if (obs_pend_post !== 3'b001)  begin n_fail++; $display("FAIL sim_pend_post: got %b expected 001", obs_pend_post); end
  endtask

  task automatic test_rsvd_mode();
    dly = '{3, 9, 4}; extra = '{0, 0, 0};
    run_seq(2'd3, 2, 1'b0, 1'b0);
    n_tests += 2;
    if (obs_post_cyc !== 11)  begin n_fail++; $display("FAIL rsvd_post_cyc: got %0d expected 11", obs_post_cyc); end
    if (obs_fid !== 2'd0)     begin n_fail++; $display("FAIL rsvd_first_id: got %0d expected 0", obs_fid); end
  endtask

  task automatic test_spurious_idle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_tests += 3;
      if (busy !== 1'b0)          begin n_fail++; $display("FAIL idle_busy k=%0d: got %b expected 0", k, busy); end
      if (job_start !== 3'b000)   begin n_fail++; $display("FAIL idle_job_start k=%0d: got %b expected 000", k, job_start); end
      if (pending !== model_pend) begin n_fail++; $display("FAIL idle_pending k=%0d: got %b expected %b", k, pending, model_pend); end
      job_done  = (k < 5) ? N'($urandom_range(0, 7)) : '0;
      post_done = (k < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) begin
        dly[i]   = $urandom_range(1, 12);
        extra[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      end
      run_seq(2'($urandom_range(0, 3)), $urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); go = 1'b1; mode = JOIN_ANY;
    @(negedge clk); go = 1'b0;
    @(negedge clk); job_done = 3'b010; go = 1'b1;
    @(negedge clk); job_done = 3'b000;
    n_tests++;
    if (post_start !== 1'b1) begin n_fail++; $display("FAIL mid_post_start: got %b expected 1", post_start); end
    @(negedge clk);
    n_tests += 3;
    if (busy !== 1'b1)       begin n_fail++; $display("FAIL mid_busy: got %b expected 1", busy); end
    if (pending !== 3'b101)  begin n_fail++; $display("FAIL mid_pending: got %b expected 101", pending); end
    if (first_id !== 2'd1)   begin n_fail++; $display("FAIL mid_first_id: got %0d expected 1", first_id); end
    rst_n = 1'b0;
    #1;
    n_tests += 5;
    if (busy !== 1'b0)         begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
    if (pending !== 3'b000)    begin n_fail++; $display("FAIL mid_rst_pending: got %b expected 000", pending); end
    if (first_id !== 2'd0)     begin n_fail++; $display("FAIL mid_rst_first_id: got %0d expected 0", first_id); end
    if (post_start !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_post_start: got %b expected 0", post_start); end
    if (done !== 1'b0)         begin n_fail++; $display("FAIL mid_rst_done: got %b expected 0", done); end
    @(negedge clk); go = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_busy: got %b expected 0", busy); end
    model_pend = '0;
  endtask

  initial begin
    test_reset();
    test_join_any();
    test_spurious_idle();
    test_join_all();
    test_join_none();
    test_simultaneous();
    test_rsvd_mode();
    test_random();
    test_reset_mid();
    test_spurious_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
